// File: rtl/fpusqr_wb_queue.sv
// Writeback collector for the divide/sqrt engines: rotating-priority accept into a FIFO,
// one issue per free slot, data trailing the tags by DATA_DLY cycles. Option: FPSQR_WB_BYPASS_EN.
module fpusqr_wb_queue #(
   parameter int NUNIT    = 3,
   parameter int DWIDTH   = 68,
   parameter int DEPTH    = 4,
   parameter int DATA_DLY = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    except,
   input  logic [NUNIT-1:0]        in_en,
   input  logic [NUNIT*9-1:0]      in_reg,
   input  logic [NUNIT*10-1:0]     in_II,
   input  logic [NUNIT*13-1:0]     in_op,
   input  logic [NUNIT*11-1:0]     in_flags,
   input  logic [NUNIT*DWIDTH-1:0] in_data,
   output logic [NUNIT-1:0]        in_ack,
   input  logic                    wb_free,
   output logic [3:0]              outEn,
   output logic [9:0]              outII,
   output logic [12:0]             outOp,
   output logic [8:0]              FUreg,
   output logic [8:0]              FUSreg,
   output logic                    FUwen,
   output logic [DWIDTH-1:0]       outAltData,
   output logic [13:0]             ret,
   output logic                    ret_en
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int UW = (NUNIT > 1) ? $clog2(NUNIT) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   function automatic logic [UW-1:0] rr_next(input logic [UW-1:0] idx);
      return (idx == UW'(NUNIT - 1)) ? '0 : idx + 1'b1;
   endfunction

   logic [8:0]        e_reg   [NUNIT];
   logic [9:0]        e_ii    [NUNIT];
   logic [12:0]       e_op    [NUNIT];
   logic [10:0]       e_flags [NUNIT];
   logic [DWIDTH-1:0] e_data  [NUNIT];

   logic [8:0]        q_reg   [DEPTH];
   logic [9:0]        q_ii    [DEPTH];
   logic [12:0]       q_op    [DEPTH];
   logic [10:0]       q_flags [DEPTH];
   logic [DWIDTH-1:0] q_data  [DEPTH];

   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic [UW-1:0]     rr_ptr;

   logic [NUNIT-1:0]  grant;
   logic [CW-1:0]     rank [NUNIT];
   logic [CW-1:0]     n_grant, n_push, free;
   logic [UW-1:0]     sel, first_idx, last_idx;
   logic              pop, byp;

   logic [8:0]        src_reg;
   logic [9:0]        src_ii;
   logic [12:0]       src_op;
   logic [10:0]       src_flags;
   logic [DWIDTH-1:0] src_data;

   logic [8:0]        tag_reg_p0;
   logic [9:0]        tag_ii_p0;
   logic [12:0]       tag_op_p0;
   logic [10:0]       tag_flags_p0;
   logic [DWIDTH-1:0] dat_p [DATA_DLY+1];
   logic [DATA_DLY:0] vld_p;

   always_comb begin
      for (int n = 0; n < NUNIT; n++) begin
         e_reg[n]   = in_reg[n*9 +: 9];
         e_ii[n]    = in_II[n*10 +: 10];
         e_op[n]    = in_op[n*13 +: 13];
         e_flags[n] = in_flags[n*11 +: 11];
         e_data[n]  = in_data[n*DWIDTH +: DWIDTH];
      end
   end

   // Free space comes from the pre-pop count, so a same-cycle pop never makes room.
   always_comb begin
      grant     = '0;
      n_grant   = '0;
      sel       = '0;
      first_idx = '0;
      last_idx  = rr_ptr;
      free      = CW'(DEPTH) - count;
      for (int n = 0; n < NUNIT; n++) rank[n] = '0;
      for (int k = 0; k < NUNIT; k++) begin
         sel = UW'((int'(rr_ptr) + k) % NUNIT);
         if (!rst && !except && in_en[sel] && (n_grant < free)) begin
            grant[sel] = 1'b1;
            rank[sel]  = n_grant;
            if (n_grant == '0) first_idx = sel;
            last_idx   = sel;
            n_grant    = n_grant + CW'(1);
         end
      end
      pop = wb_free && (count != '0) && !except;
`ifdef FPSQR_WB_BYPASS_EN
      byp = wb_free && (count == '0) && (n_grant != '0) && !except;
`else
      byp = 1'b0;
`endif
      n_push = n_grant - CW'(byp);
   end

   assign in_ack = grant;

   always_comb begin
      src_reg   = q_reg[rd_ptr];
      src_ii    = q_ii[rd_ptr];
      src_op    = q_op[rd_ptr];
      src_flags = q_flags[rd_ptr];
      src_data  = q_data[rd_ptr];
`ifdef FPSQR_WB_BYPASS_EN
      if (byp) begin
         src_reg   = e_reg[first_idx];
         src_ii    = e_ii[first_idx];
         src_op    = e_op[first_idx];
         src_flags = e_flags[first_idx];
         src_data  = e_data[first_idx];
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rr_ptr <= '0;
         vld_p  <= '0;
      end else begin
         if (except) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            wr_ptr <= wr_ptr + AW'(n_push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + n_push - CW'(pop);
         end
         if (n_grant != '0) rr_ptr <= rr_next(last_idx);
         vld_p <= {vld_p[DATA_DLY-1:0], pop | byp};
      end
   end

   // Stage p0: FIFO write and tag capture; valid-gated, so no reset needed.
   always_ff @(posedge clk) begin
      for (int n = 0; n < NUNIT; n++) begin
         if (grant[n] && !(byp && (UW'(n) == first_idx))) begin
            q_reg[wr_ptr + AW'(rank[n] - CW'(byp))]   <= e_reg[n];
            q_ii[wr_ptr + AW'(rank[n] - CW'(byp))]    <= e_ii[n];
            q_op[wr_ptr + AW'(rank[n] - CW'(byp))]    <= e_op[n];
            q_flags[wr_ptr + AW'(rank[n] - CW'(byp))] <= e_flags[n];
            q_data[wr_ptr + AW'(rank[n] - CW'(byp))]  <= e_data[n];
         end
      end
      if (pop || byp) begin
         tag_reg_p0   <= src_reg;
         tag_ii_p0    <= src_ii;
         tag_op_p0    <= src_op;
         tag_flags_p0 <= src_flags;
      end
      dat_p[0] <= src_data;
      for (int i = 1; i <= DATA_DLY; i++) dat_p[i] <= dat_p[i-1];
   end

   assign FUwen      = vld_p[0];
   assign ret_en     = vld_p[0];
   assign outEn      = vld_p[0] ? 4'b1001 : 4'b0000;
   assign FUSreg     = vld_p[0] ? 9'h1ff : 9'h000;
   assign FUreg      = vld_p[0] ? tag_reg_p0 : 9'h000;
   assign outII      = vld_p[0] ? tag_ii_p0 : 10'h000;
   assign outOp      = vld_p[0] ? tag_op_p0 : 13'h0000;
   assign ret        = vld_p[0] ? {3'b000, tag_flags_p0} : 14'h0000;
   assign outAltData = vld_p[DATA_DLY] ? dat_p[DATA_DLY] : '0;

endmodule

// File: tb/tb_fpusqr_wb_queue.sv
// Randomised bench for fpusqr_wb_queue against a queue-based reference model.
module tb_fpusqr_wb_queue;

   localparam int NUNIT    = 3;
   localparam int DWIDTH   = 68;
   localparam int DEPTH    = 4;
   localparam int DATA_DLY = 5;
`ifdef FPSQR_WB_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    except = 1'b0;
   logic                    wb_free = 1'b0;
   logic [NUNIT-1:0]        in_en = '0;
   logic [NUNIT*9-1:0]      in_reg = '0;
   logic [NUNIT*10-1:0]     in_II = '0;
   logic [NUNIT*13-1:0]     in_op = '0;
   logic [NUNIT*11-1:0]     in_flags = '0;
   logic [NUNIT*DWIDTH-1:0] in_data = '0;
   logic [NUNIT-1:0]        in_ack;
   logic [3:0]              outEn;
   logic [9:0]              outII;
   logic [12:0]             outOp;
   logic [8:0]              FUreg, FUSreg;
   logic                    FUwen, ret_en;
   logic [DWIDTH-1:0]       outAltData;
   logic [13:0]             ret;

   fpusqr_wb_queue #(.NUNIT(NUNIT), .DWIDTH(DWIDTH), .DEPTH(DEPTH), .DATA_DLY(DATA_DLY)) dut (
      .clk(clk), .rst(rst), .except(except), .in_en(in_en), .in_reg(in_reg), .in_II(in_II),
      .in_op(in_op), .in_flags(in_flags), .in_data(in_data), .in_ack(in_ack), .wb_free(wb_free),
      .outEn(outEn), .outII(outII), .outOp(outOp), .FUreg(FUreg), .FUSreg(FUSreg), .FUwen(FUwen),
      .outAltData(outAltData), .ret(ret), .ret_en(ret_en)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [8:0]        r;
      logic [9:0]        ii;
      logic [12:0]       op;
      logic [10:0]       fl;
      logic [DWIDTH-1:0] d;
   } ent_t;

   wire [60:0] tagv = {outEn, outII, outOp, FUreg, FUSreg, FUwen, ret, ret_en};

   ent_t              q[$];
   ent_t              pend [NUNIT];
   bit                pend_v [NUNIT];
   int                g_order[$];
   int                rr;
   bit                m_iss_v;
   ent_t              m_iss;
   logic [DWIDTH-1:0] sched [int];
   logic [NUNIT-1:0]  m_ack;
   logic [60:0]       m_tagv;
   logic [DWIDTH-1:0] m_data;
   bit                cur_rst, cur_ex, cur_wf;
   int                cyc, checks, errors;

   function automatic ent_t rand_ent();
      ent_t e;
      e.r  = 9'($urandom);
      e.ii = 10'($urandom);
      e.op = 13'($urandom);
      e.fl = 11'($urandom);
      e.d  = DWIDTH'({$urandom, $urandom, $urandom});
      return e;
   endfunction

   // Drive one cycle's inputs and form the model's expectations for what is visible now.
   task automatic cycle_begin(input bit r, input bit ex, input bit wf);
      int free;
      @(negedge clk);
      rst = r; except = ex; wb_free = wf;
      cur_rst = r; cur_ex = ex; cur_wf = wf;
      for (int n = 0; n < NUNIT; n++) begin
         in_en[n]                   = pend_v[n];
         in_reg[n*9 +: 9]           = pend[n].r;
         in_II[n*10 +: 10]          = pend[n].ii;
         in_op[n*13 +: 13]          = pend[n].op;
         in_flags[n*11 +: 11]       = pend[n].fl;
         in_data[n*DWIDTH +: DWIDTH] = pend[n].d;
      end
      #1;
      m_ack = '0;
      g_order.delete();
      if (!r && !ex) begin
         free = DEPTH - q.size();
         for (int k = 0; k < NUNIT; k++) begin
            int idx;
            idx = (rr + k) % NUNIT;
            if (pend_v[idx] && g_order.size() < free) begin
               m_ack[idx] = 1'b1;
               g_order.push_back(idx);
            end
         end
      end
      m_tagv = m_iss_v ? {4'b1001, m_iss.ii, m_iss.op, m_iss.r, 9'h1ff, 1'b1, 3'b000, m_iss.fl, 1'b1} : '0;
      m_data = sched.exists(cyc) ? sched[cyc] : '0;
   endtask

   // Advance the reference model across the clock edge.
   task automatic cycle_end();
      bit   nv;
      ent_t ne;
      nv = 1'b0;
      ne = '0;
      if (cur_rst) begin
         q.delete();
         rr = 0;
         m_iss_v = 1'b0;
         sched.delete();
         cyc++;
         return;
      end
      if (cur_ex) begin
         q.delete();
      end else begin
         if (g_order.size() > 0) rr = (g_order[g_order.size()-1] + 1) % NUNIT;
         for (int n = 0; n < NUNIT; n++) if (m_ack[n]) pend_v[n] = 1'b0;
`ifdef FPSQR_WB_BYPASS_EN
         if (q.size() == 0 && cur_wf && g_order.size() > 0) begin
            nv = 1'b1;
            ne = pend[g_order.pop_front()];
         end else
`endif
         if (cur_wf && q.size() != 0) begin
            nv = 1'b1;
            ne = q.pop_front();
         end
         foreach (g_order[i]) q.push_back(pend[g_order[i]]);
      end
      m_iss_v = nv;
      if (nv) begin
         m_iss = ne;
         sched[cyc + 1 + DATA_DLY] = ne.d;
      end
      cyc++;
   endtask

   task automatic test_reset();
      for (int n = 0; n < NUNIT; n++) begin
         pend[n]   = rand_ent();
         pend_v[n] = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
         cycle_begin(1'b1, 1'b0, 1'b1);
         checks++;
         if ({in_ack, tagv, outAltData} !== '0) begin
            errors++;
            $display("FAIL reset cyc=%0d ack=%b tags=%h data=%h required all zero", cyc, in_ack, tagv, outAltData);
         end
         cycle_end();
      end
      for (int n = 0; n < NUNIT; n++) pend_v[n] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cycle_begin(1'b0, 1'b0, 1'b1);
         checks++;
         if ({in_ack, tagv, outAltData} !== {m_ack, m_tagv, m_data}) begin
            errors++;
            $display("FAIL idle cyc=%0d ack=%b/%b tags=%h/%h data=%h/%h", cyc, in_ack, m_ack, tagv, m_tagv, outAltData, m_data);
         end
         cycle_end();
      end
   endtask

   task automatic test_single();
      int t0;
      ent_t e;
      e = rand_ent();
      e.r = 9'h012;
      e.ii = 10'h055;
      pend[0] = e;
      pend_v[0] = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 12; i++) begin
         cycle_begin(1'b0, 1'b0, 1'b1);
         checks++;
         if ({in_ack, tagv, outAltData} !== {m_ack, m_tagv, m_data}) begin
            errors++;
            $display("FAIL single cyc=%0d ack=%b/%b tags=%h/%h data=%h/%h", cyc, in_ack, m_ack, tagv, m_tagv, outAltData, m_data);
         end
         if (cyc == t0) begin
            checks++;
            if (in_ack !== 3'b001) begin
               errors++;
               $display("FAIL single_ack got %b want 001", in_ack);
            end
         end
         if (cyc == t0 + LAT) begin
            checks++;
            if ({FUwen, outEn, FUreg, outII} !== {1'b1, 4'b1001, 9'h012, 10'h055}) begin
               errors++;
               $display("FAIL single_latency wen=%b en=%b reg=%h ii=%h want 1 1001 012 055", FUwen, outEn, FUreg, outII);
            end
         end
         if (cyc == t0 + LAT + DATA_DLY) begin
            checks++;
            if (outAltData !== e.d) begin
               errors++;
               $display("FAIL single_data got %h want %h", outAltData, e.d);
            end
         end
         cycle_end();
      end
   endtask

   task automatic test_round_robin();
      int seen[$];
      for (int n = 0; n < NUNIT; n++) begin
         pend[n]   = rand_ent();
         pend[n].r = 9'h100 + 9'(n);
         pend_v[n] = 1'b1;
      end
      for (int i = 0; i < 10; i++) begin
         cycle_begin(1'b0, 1'b0, 1'b1);
         checks++;
         if ({in_ack, tagv, outAltData} !== {m_ack, m_tagv, m_data}) begin
            errors++;
            $display("FAIL rr cyc=%0d ack=%b/%b tags=%h/%h data=%h/%h", cyc, in_ack, m_ack, tagv, m_tagv, outAltData, m_data);
         end
         if (FUwen === 1'b1) seen.push_back(int'(FUreg));
         cycle_end();
      end
      checks++;
      if (seen.size() != 3 || seen[0] != 'h101 || seen[1] != 'h102 || seen[2] != 'h100) begin
         errors++;
         $display("FAIL rr_order got %p want '{257,258,256}", seen);
      end
   endtask

   task automatic test_full();
      int offered, acks;
      for (int n = 0; n < NUNIT; n++) begin
         pend[n]   = rand_ent();
         pend_v[n] = 1'b1;
      end
      offered = NUNIT;
      acks = 0;
      for (int i = 0; i < 8; i++) begin
         cycle_begin(1'b0, 1'b0, 1'b0);
         checks++;
         if ({in_ack, tagv, outAltData} !== {m_ack, m_tagv, m_data}) begin
            errors++;
            $display("FAIL full cyc=%0d ack=%b/%b tags=%h/%h data=%h/%h", cyc, in_ack, m_ack, tagv, m_tagv, outAltData, m_data);
         end
         acks += $countones(in_ack);
         cycle_end();
         for (int n = 0; n < NUNIT; n++)
            if (!pend_v[n] && offered < 6) begin
               pend[n] = rand_ent();
               pend_v[n] = 1'b1;
               offered++;
            end
      end
      checks++;
      if (acks != DEPTH) begin
         errors++;
         $display("FAIL full_acks got %0d want %0d", acks, DEPTH);
      end
      cycle_begin(1'b0, 1'b0, 1'b1);
      checks++;
      if (in_ack !== 3'b000 || m_ack !== 3'b000) begin
         errors++;
         $display("FAIL full_pop_noack got %b want 000", in_ack);
      end
      cycle_end();
      cycle_begin(1'b0, 1'b0, 1'b0);
      checks++;
      if ($countones(in_ack) != 1 || in_ack !== m_ack) begin
         errors++;
         $display("FAIL full_next_ack got %b want %b", in_ack, m_ack);
      end
      cycle_end();
      for (int i = 0; i < 14; i++) begin
         cycle_begin(1'b0, 1'b0, 1'b1);
         checks++;
         if ({in_ack, tagv, outAltData} !== {m_ack, m_tagv, m_data}) begin
            errors++;
            $display("FAIL drain cyc=%0d ack=%b/%b tags=%h/%h data=%h/%h", cyc, in_ack, m_ack, tagv, m_tagv, outAltData, m_data);
         end
         cycle_end();
      end
   endtask

   task automatic test_except();
      bit wf_seq [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      int beats;
      for (int n = 0; n < NUNIT; n++) begin
         pend[n]   = rand_ent();
         pend_v[n] = 1'b1;
      end
      for (int s = 0; s < 4; s++) begin
         if (s == 1) begin pend[0] = rand_ent(); pend_v[0] = 1'b1; end
         if (s == 3) begin pend[2] = rand_ent(); pend_v[2] = 1'b1; end
         cycle_begin(1'b0, 1'b0, wf_seq[s]);
         checks++;
         if ({in_ack, tagv, outAltData} !== {m_ack, m_tagv, m_data}) begin
            errors++;
            $display("FAIL exc_fill cyc=%0d ack=%b/%b tags=%h/%h data=%h/%h", cyc, in_ack, m_ack, tagv, m_tagv, outAltData, m_data);
         end
         cycle_end();
      end
      beats = 0;
      for (int i = 0; i < 11; i++) begin
         cycle_begin(1'b0, i == 0, 1'b1);
         checks++;
         if ({in_ack, tagv, outAltData} !== {m_ack, m_tagv, m_data}) begin
            errors++;
            $display("FAIL exc cyc=%0d ack=%b/%b tags=%h/%h data=%h/%h", cyc, in_ack, m_ack, tagv, m_tagv, outAltData, m_data);
         end
         if (i > 0) begin
            checks++;
            if (FUwen !== 1'b0) begin
               errors++;
               $display("FAIL exc_nowen cyc=%0d got %b want 0", cyc, FUwen);
            end
         end
         if (outAltData !== '0) beats++;
         cycle_end();
      end
      checks++;
      if (beats != 2) begin
         errors++;
         $display("FAIL exc_beats got %0d want 2", beats);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         for (int n = 0; n < NUNIT; n++)
            if (!pend_v[n] && $urandom_range(1) == 1 && i < 480) begin
               pend[n] = rand_ent();
               pend_v[n] = 1'b1;
            end
         cycle_begin($urandom_range(99) == 0, $urandom_range(29) == 0,
                     (i >= 480) || ($urandom_range(9) < 7));
         checks++;
         if ({in_ack, tagv, outAltData} !== {m_ack, m_tagv, m_data}) begin
            errors++;
            $display("FAIL random cyc=%0d ack=%b/%b tags=%h/%h data=%h/%h", cyc, in_ack, m_ack, tagv, m_tagv, outAltData, m_data);
         end
         cycle_end();
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc = 0;
      rr = 0;
      m_iss_v = 1'b0;
      m_iss = '0;
      for (int n = 0; n < NUNIT; n++) begin
         pend[n] = rand_ent();
         pend_v[n] = 1'b0;
      end
      test_reset();
      test_single();
      test_round_robin();
      test_full();
      test_except();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
